// File: rtl/pipe_collide_score.sv
// rtl/pipe_collide_score.sv - per-frame collision/pass judge, game FSM and BCD score keeper
module pipe_collide_score #(
   parameter logic [9:0] BIRD_W     = 10'd34,
   parameter logic [9:0] BIRD_H     = 10'd24,
   parameter logic [9:0] GAP        = 10'd120,
   parameter logic [9:0] MIN_Y      = 10'd45,
   parameter logic [9:0] FLOOR_Y    = 10'd420,
   parameter logic [5:0] HIT_FRAMES = 6'd30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       start,
   input  logic [9:0] pipe_l,
   input  logic [9:0] pipe_r,
   input  logic [9:0] pipe_t,
   input  logic [9:0] pipe_b,
   input  logic [9:0] bird_x,
   input  logic [9:0] bird_y,
   output logic [1:0] game_state,
   output logic       freeze,
   output logic       hit,
   output logic [7:0] score_bcd,
   output logic [7:0] best_bcd
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_PLAY = 2'b01,
      S_HIT  = 2'b10,
      S_OVER = 2'b11
   } state_t;

   state_t      r_state, w_state_nx;
   logic        r_freeze;
   logic        r_hit, w_hit_nx;
   logic [7:0]  r_score, w_score_nx;
   logic [7:0]  r_best, w_best_nx;
   logic        r_passed, w_passed_nx;
   logic [5:0]  r_cnt, w_cnt_nx;
   logic        r_start_q;

   logic        w_start_rise;
   logic [10:0] w_bird_right, w_bird_bot, w_gap_bot;
   logic        w_h_ovl, w_top_hit, w_low_hit, w_bound_hit, w_collide, w_behind;
   logic [7:0]  w_score_inc;
   logic        w_unused_pipe_t;

   // The top-pipe top edge is reserved for later geometry; it does not affect collision.
   assign w_unused_pipe_t = ^pipe_t;

   assign w_start_rise = start & ~r_start_q;

   // 11-bit sums so bird edges near the screen limit never wrap.
   assign w_bird_right = {1'b0, bird_x} + {1'b0, BIRD_W};
   assign w_bird_bot   = {1'b0, bird_y} + {1'b0, BIRD_H};
   assign w_gap_bot    = {1'b0, pipe_b} + {1'b0, GAP};

   assign w_h_ovl     = (w_bird_right > {1'b0, pipe_l}) && (bird_x < pipe_r);
   assign w_top_hit   = w_h_ovl && (bird_y <= pipe_b);
   assign w_low_hit   = w_h_ovl && (w_bird_bot > w_gap_bot);
   assign w_bound_hit = (bird_y <= MIN_Y) || (w_bird_bot >= {1'b0, FLOOR_Y});
   assign w_collide   = w_top_hit | w_low_hit | w_bound_hit;
   assign w_behind    = (pipe_r < bird_x);

   // BCD increment that saturates at 99.
   always_comb begin
      w_score_inc = r_score;
      if (r_score == 8'h99)
         w_score_inc = 8'h99;
      else if (r_score[3:0] == 4'd9)
         w_score_inc = {r_score[7:4] + 4'd1, 4'd0};
      else
         w_score_inc = {r_score[7:4], r_score[3:0] + 4'd1};
   end

   // Next-state and next-value logic for the game FSM and score bookkeeping.
   always_comb begin
      w_state_nx  = r_state;
      w_hit_nx    = 1'b0;
      w_score_nx  = r_score;
      w_best_nx   = r_best;
      w_passed_nx = r_passed;
      w_cnt_nx    = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_start_rise) begin
               w_state_nx  = S_PLAY;
               w_score_nx  = 8'h00;
               w_passed_nx = 1'b0;
            end
         end
         S_PLAY: begin
            if (frame_tick) begin
               if (w_collide) begin
                  w_state_nx = S_HIT;
                  w_hit_nx   = 1'b1;
                  w_cnt_nx   = 6'd0;
               end else if (w_behind && !r_passed) begin
                  w_score_nx  = w_score_inc;
                  w_passed_nx = 1'b1;
               end else if (!w_behind) begin
                  w_passed_nx = 1'b0;
               end
            end
         end
         S_HIT: begin
            if (frame_tick) begin
               if (r_cnt == HIT_FRAMES - 6'd1) begin
                  w_state_nx = S_OVER;
                  if (r_score > r_best)
                     w_best_nx = r_score;
               end else begin
                  w_cnt_nx = r_cnt + 6'd1;
               end
            end
         end
         S_OVER: begin
            if (w_start_rise)
               w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // State and datapath registers; freeze is registered with the state it describes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_freeze  <= 1'b1;
         r_hit     <= 1'b0;
         r_score   <= 8'h00;
         r_best    <= 8'h00;
         r_passed  <= 1'b0;
         r_cnt     <= 6'd0;
         r_start_q <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_freeze  <= (w_state_nx != S_PLAY);
         r_hit     <= w_hit_nx;
         r_score   <= w_score_nx;
         r_best    <= w_best_nx;
         r_passed  <= w_passed_nx;
         r_cnt     <= w_cnt_nx;
         r_start_q <= start;
      end
   end

   assign game_state = r_state;
   assign freeze     = r_freeze;
   assign hit        = r_hit;
   assign score_bcd  = r_score;
   assign best_bcd   = r_best;

endmodule
